// File: rtl/wb_master_arbiter_if.sv
// Classic-cycle Wishbone bundle shared by both master ports and the interconnect port
// of wb_master_arbiter. dat_w flows master->slave, dat_r flows slave->master.
interface wb_master_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter; the granted master owns the bus for its whole cyc.
// Optional bus watchdog with DRAIN state: define WB_MASTER_ARBITER_TIMEOUT_EN.
module wb_master_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    wb_master_arbiter_if.slave   m0,
    wb_master_arbiter_if.slave   m1,
    wb_master_arbiter_if.master  s,
    output logic [1:0]           gnt_o
);

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, DRAIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
`endif

    state_t state_reg, state_next;
    logic   last_reg, last_next;    // 1: m1 was granted last, so m0 wins a tie
    logic   own0, own1;
    logic   owner_cyc;
    logic   timeout;

    assign own0      = (state_reg == OWN0);
    assign own1      = (state_reg == OWN1);
    assign owner_cyc = (own0 & m0.cyc) | (own1 & m1.cyc);

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
    logic [15:0] cnt_reg, cnt_next;
    logic        owner_reg, owner_next;

    // Fires in the cycle the stall count hits the limit; that cycle already drops cyc/stb.
    assign timeout = (own0 | own1) & owner_cyc & (cnt_reg == 16'(TIMEOUT_CYCLES));
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = ^16'(TIMEOUT_CYCLES);
`endif

    // State register
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
            cnt_reg   <= 16'd0;
            owner_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (m0.cyc && m1.cyc)
                    state_next = last_reg ? OWN0 : OWN1;
                else if (m0.cyc)
                    state_next = OWN0;
                else if (m1.cyc)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!m0.cyc) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                end
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
                else if (timeout)
                    state_next = DRAIN;
`endif
            end
            OWN1: begin
                if (!m1.cyc) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                end
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
                else if (timeout)
                    state_next = DRAIN;
`endif
            end
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
            DRAIN: begin
                if (!(owner_reg ? m1.cyc : m0.cyc)) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
    // Stall counter and owner tracking for the drain path
    always_comb begin
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        if (state_next == OWN0)
            owner_next = 1'b0;
        else if (state_next == OWN1)
            owner_next = 1'b1;

        if ((state_next != state_reg) || !(own0 | own1))
            cnt_next = 16'd0;
        else if (s.ack || s.err)
            cnt_next = 16'd0;
        else if (s.stb)
            cnt_next = cnt_reg + 16'd1;
    end
`endif

    // Output logic: combinational mux selected by the registered grant
    always_comb begin
        s.adr    = '0;
        s.dat_w  = '0;
        s.sel    = '0;
        s.we     = 1'b0;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        m0.dat_r = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.dat_r = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        if (own0) begin
            s.adr    = m0.adr;
            s.dat_w  = m0.dat_w;
            s.sel    = m0.sel;
            s.we     = m0.we;
            s.cyc    = m0.cyc & ~timeout;
            s.stb    = m0.cyc & m0.stb & ~timeout;
            m0.dat_r = s.dat_r;
            m0.ack   = s.ack & m0.cyc & m0.stb & ~timeout;
            m0.err   = (s.err & m0.cyc & m0.stb & ~timeout) | timeout;
        end else if (own1) begin
            s.adr    = m1.adr;
            s.dat_w  = m1.dat_w;
            s.sel    = m1.sel;
            s.we     = m1.we;
            s.cyc    = m1.cyc & ~timeout;
            s.stb    = m1.cyc & m1.stb & ~timeout;
            m1.dat_r = s.dat_r;
            m1.ack   = s.ack & m1.cyc & m1.stb & ~timeout;
            m1.err   = (s.err & m1.cyc & m1.stb & ~timeout) | timeout;
        end
    end

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
    // The drained master still shows as granted until it lets go of cyc
    assign gnt_o = {own1, own0} |
                   ((state_reg == DRAIN) ? {owner_reg, ~owner_reg} : 2'b00);
`else
    assign gnt_o = {own1, own0};
`endif

endmodule
